// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment seconds counter.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied in the decoder.
package seven_seg_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_MAX = digit_t'(9);

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to seven-segment decoder.
// Define SEVEN_SEG_COMMON_ANODE_EN for active-low (common-anode) segment drive.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  digit_t     i_digit,
    output logic [6:0] o_seg
);

    logic [6:0] w_seg_ah;

    always_comb begin
        w_seg_ah = SEG_BLANK;
        case (i_digit)
            digit_t'(0): w_seg_ah = SEG_0;
            digit_t'(1): w_seg_ah = SEG_1;
            digit_t'(2): w_seg_ah = SEG_2;
            digit_t'(3): w_seg_ah = SEG_3;
            digit_t'(4): w_seg_ah = SEG_4;
            digit_t'(5): w_seg_ah = SEG_5;
            digit_t'(6): w_seg_ah = SEG_6;
            digit_t'(7): w_seg_ah = SEG_7;
            digit_t'(8): w_seg_ah = SEG_8;
            digit_t'(9): w_seg_ah = SEG_9;
            default:     w_seg_ah = SEG_BLANK;
        endcase
    end

`ifdef SEVEN_SEG_COMMON_ANODE_EN
    assign o_seg = ~w_seg_ah;
`else
    assign o_seg = w_seg_ah;
`endif

endmodule

// File: rtl/seven_seg_seconds.sv
// Free-running decimal seconds counter driving one seven-segment digit.
// Polarity option SEVEN_SEG_COMMON_ANODE_EN is handled inside seven_seg_decoder.
module seven_seg_seconds
    import seven_seg_pkg::*;
#(
    parameter int unsigned COMPARE = 16_000_000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [6:0] led_out
);

    // COMPARE = 1 would give a zero-width counter; keep at least one bit.
    localparam int CNT_W = (COMPARE > 1) ? $clog2(COMPARE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COMPARE - 1);

    logic [CNT_W-1:0] r_tick_cnt;
    digit_t           r_digit;
    logic             w_tick;

    assign w_tick = (r_tick_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit <= '0;
        end else if (w_tick) begin
            r_digit <= (r_digit == DIGIT_MAX) ? digit_t'(0) : r_digit + digit_t'(1);
        end
    end

    seven_seg_decoder u_decoder (
        .i_digit (r_digit),
        .o_seg   (led_out)
    );

endmodule

// File: tb/tb_seven_seg_seconds.sv
// Directed bench for seven_seg_seconds: one instance at COMPARE=10, one at COMPARE=1,
// sharing clock and reset. Expected patterns follow SEVEN_SEG_COMMON_ANODE_EN when defined.
`timescale 1ns/1ps
module tb_seven_seg_seconds;

    logic       clk;
    logic       reset;
    logic [6:0] led10;
    logic [6:0] led1;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_seconds #(.COMPARE(10)) dut10 (
        .clk     (clk),
        .reset   (reset),
        .led_out (led10)
    );

    seven_seg_seconds #(.COMPARE(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .led_out (led1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'h3F;
            1: s = 7'h06;
            2: s = 7'h5B;
            3: s = 7'h4F;
            4: s = 7'h66;
            5: s = 7'h6D;
            6: s = 7'h7D;
            7: s = 7'h07;
            8: s = 7'h7F;
            9: s = 7'h6F;
            default: s = 7'h00;
        endcase
`ifdef SEVEN_SEG_COMMON_ANODE_EN
        s = ~s;
`endif
        return s;
    endfunction

    task automatic check_seg(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: led_out=%02h expected=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        #1;
        check_seg("reset_noclk_c10", led10, exp_seg(0));
        check_seg("reset_noclk_c1", led1, exp_seg(0));
`ifdef SEVEN_SEG_COMMON_ANODE_EN
        check_seg("reset_ca_raw", led10, 7'h40);
`endif

        repeat (100) step_edge();
        check_seg("reset_hold_c10", led10, exp_seg(0));
        check_seg("reset_hold_c1", led1, exp_seg(0));

        // Release between edges; next rising edge is prescaler cycle 0.
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            step_edge();
            check_seg($sformatf("count_c10_e%0d", e), led10, exp_seg((e / 10) % 10));
            check_seg($sformatf("count_c1_e%0d", e), led1, exp_seg(e % 10));
            if (e == 9)   check_seg("pre_step_e9", led10, 7'h3F ^ ((exp_seg(0) ^ 7'h3F)));
            if (e == 10)  check_seg("first_step_e10", led10, exp_seg(1));
            if (e == 20)  check_seg("second_step_e20", led10, exp_seg(2));
            if (e == 90)  check_seg("nine_e90", led10, exp_seg(9));
            if (e == 100) check_seg("wrap_e100", led10, exp_seg(0));
        end
`ifdef SEVEN_SEG_COMMON_ANODE_EN
`else
        check_seg("wrap_raw_c1", led1, 7'h3F);
`endif

        // Advance to digit 4 plus 5 edges, then pulse reset between edges.
        repeat (45) step_edge();
        check_seg("mid_digit4", led10, exp_seg(4));
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_seg("async_clear_c10", led10, exp_seg(0));
        check_seg("async_clear_c1", led1, exp_seg(0));
        #1;
        reset = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step_edge();
            check_seg($sformatf("after_rst_c10_e%0d", e), led10, exp_seg(e / 10));
            check_seg($sformatf("after_rst_c1_e%0d", e), led1, exp_seg(e % 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
